n_to_one_mux_arbiter: RTL and testbench
=======================================

N_TO_ONE_MUX_ARBITER -- requirements
Module: n_to_one_mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, bit width of each data channel; SHALL be >= 1.
REQ-002 Parameter CHANNELS, default 4, number of input channels; SHALL be >= 2.
REQ-003 Parameter SEL_W, default $clog2(CHANNELS), width of selector.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_data  input  CHANNELS*WIDTH  packed channel data; channel i SHALL occupy bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  CHANNELS  per-channel valid.
REQ-008 in_ready  output  CHANNELS  per-channel ready.
REQ-009 selector  input  SEL_W  channel index used in select mode.
REQ-010 mode  input  1  0 = select mode, 1 = round-robin mode.
REQ-011 out_data  output  WIDTH  registered output word.
REQ-012 out_valid  output  1  output word valid.
REQ-013 out_ready  input  1  downstream accepts output word.

Function
REQ-014 Block SHALL contain exactly one output register stage; data latency input-to-output SHALL be 1 cycle.
REQ-015 Channel i transfer SHALL occur when in_valid[i] && in_ready[i] at a rising edge.
REQ-016 Output transfer SHALL occur when out_valid && out_ready at a rising edge.
REQ-017 Register SHALL be free when !out_valid || out_ready; in_ready SHALL be combinational from grant and free.
REQ-018 in_ready[i] SHALL be 1 only for i == grant and only while register free; at most one in_ready bit SHALL be 1.
REQ-019 On an input transfer, out_data SHALL load the granted channel's word and out_valid SHALL become 1.
REQ-020 On an output transfer without an input transfer, out_valid SHALL become 0 and out_data SHALL hold its value.
REQ-021 Simultaneous input and output transfer SHALL replace the word with no bubble (full throughput, one word per cycle).
REQ-022 While out_valid && !out_ready, out_data and out_valid SHALL be held stable.
REQ-023 Select mode: grant SHALL equal selector; if selector >= CHANNELS, no grant, all in_ready 0.
REQ-024 Select mode: in_ready[selector] SHALL follow free regardless of in_valid[selector].
REQ-025 Round-robin mode: grant SHALL be first channel with in_valid set, searching from ptr+1 upward and wrapping CHANNELS-1 -> 0; none valid -> no grant.
REQ-026 Round-robin pointer ptr (SEL_W bits) SHALL update to the granted index only on an input transfer in round-robin mode.
REQ-027 ptr SHALL be unchanged in select mode; mode changes SHALL take effect in the same cycle without flushing the output register.

Reset
REQ-028 While rst_n == 0 at a rising edge: out_valid SHALL become 0, out_data all zeros, ptr CHANNELS-1 (channel 0 highest priority first).
REQ-029 in_ready SHALL be all 0 while rst_n == 0; no transfer SHALL be recorded during reset.
REQ-030 Reset mid-operation SHALL discard any held output word; no partial state SHALL survive.

Configuration
REQ-031 Macro MUX_ARB_ROUND_ROBIN_EN defined: mode input and round-robin logic (REQ-025/026) SHALL be present.
REQ-032 Macro MUX_ARB_ROUND_ROBIN_EN undefined: ptr SHALL not exist, mode SHALL be ignored, block SHALL always behave as select mode.

Verification
REQ-033 WIDTH=32, CHANNELS=4, mode=0, selector=2, in_valid=4'b0100, in_data ch2=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF; in_ready=4'b0100.
REQ-034 Mode=0, out_valid=1 held, out_ready=0 for 3 cycles -> in_ready=0, out_data stable; out_ready=1 with ch2 valid -> new word loaded same edge, no bubble.
REQ-035 After reset, mode=1, in_valid=4'b1111 continuously, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-036 Mode=1, ptr=1, in_valid=4'b0001 -> grant wraps to channel 0; ptr becomes 0.
REQ-037 Mode=0, selector=5 with CHANNELS=4 (SEL_W=3) -> in_ready=0, out_valid stays 0.
REQ-038 out_valid=1 then rst_n=0 one cycle -> out_valid=0, out_data=0, next mode=1 grant starts at channel 0; build without MUX_ARB_ROUND_ROBIN_EN, mode=1 -> select-mode behaviour.

Source files
------------

// File: rtl/n_to_one_mux_arbiter.sv
// N-to-1 valid/ready mux with a single registered output stage.
// Round-robin mode is compiled in only when MUX_ARB_ROUND_ROBIN_EN is defined.
module n_to_one_mux_arbiter #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          selector,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic             free;
  logic             grant_vld;
  logic             in_xfer;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;

`ifdef MUX_ARB_ROUND_ROBIN_EN
  logic [SEL_W-1:0] ptr;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  // Round-robin scans downward so the nearest channel after ptr wins.
  always_comb begin
    grant     = selector;
    grant_vld = int'(selector) < CHANNELS;
`ifdef MUX_ARB_ROUND_ROBIN_EN
    if (mode) begin
      grant     = '0;
      grant_vld = 1'b0;
      for (int k = CHANNELS; k >= 1; k--) begin
        if (in_valid[(int'(ptr) + k) % CHANNELS]) begin
          grant     = SEL_W'((int'(ptr) + k) % CHANNELS);
          grant_vld = 1'b1;
        end
      end
    end
`endif
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_vld && int'(grant) == i) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign free = !out_valid || out_ready;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = rst_n && free && grant_vld
                    && (int'(grant) == i);
    end
  end

  assign in_xfer = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= SEL_W'(CHANNELS - 1);
    end else if (in_xfer && mode) begin
      ptr <= grant;
    end
  end
`endif

endmodule

// File: tb/tb_n_to_one_mux_arbiter.sv
// Randomized bench for n_to_one_mux_arbiter against a queue-free
// behavioural model of the grant rules and the output register.
module tb_n_to_one_mux_arbiter;

  localparam int W = 32;
  localparam int CH = 4;
  localparam int SW = 3;
`ifdef MUX_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0] in_valid;
  logic [CH-1:0] in_ready;
  logic [SW-1:0] selector;
  logic          mode;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;

  n_to_one_mux_arbiter #(
    .WIDTH(W), .CHANNELS(CH), .SEL_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .selector(selector),
    .mode(mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_data;
  logic         m_valid;
  int           m_ptr;
  logic [CH-1:0] seen_rdy;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_grant(input logic m,
                                   input logic [SW-1:0] s,
                                   input logic [CH-1:0] v);
    if (RR_EN && m) begin
      for (int k = 1; k <= CH; k++)
        if (v[(m_ptr + k) % CH]) return (m_ptr + k) % CH;
      return -1;
    end
    return (int'(s) < CH) ? int'(s) : -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ptr   = CH - 1;
  endtask

  // Apply one cycle at the falling edge; model advances at the rising edge.
  task automatic step(input logic r, input logic m,
                      input logic [SW-1:0] s,
                      input logic [CH-1:0] v,
                      input logic ordy,
                      input logic [W-1:0] d2);
    int g;
    logic [CH-1:0] exp_rdy;
    rst_n = r; mode = m; selector = s;
    in_valid = v; out_ready = ordy;
    for (int i = 0; i < CH; i++)
      in_data[i*W +: W] = $urandom();
    if (d2 != '0) in_data[2*W +: W] = d2;
    #1;
    g = ref_grant(m, s, v);
    exp_rdy = '0;
    if (r && g >= 0 && (!m_valid || ordy))
      exp_rdy[g] = 1'b1;
    seen_rdy = in_ready;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", out_data, m_data);
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else if (exp_rdy != '0 && v[g]) begin
      m_data  = in_data[g*W +: W];
      m_valid = 1'b1;
      if (RR_EN && m) m_ptr = g;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  logic [W-1:0] held;

  initial begin
    rst_n = 1'b0; mode = 1'b0; selector = '0;
    in_valid = '0; out_ready = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Basic select-mode transfer of channel 2.
    step(1, 0, 2, 4'b0100, 1, 32'hDEADBEEF);
    check("sel_rdy", 32'(seen_rdy), 32'h4);
    check("sel_valid", 32'(out_valid), 32'h1);
    check("sel_data", out_data, 32'hDEADBEEF);

    // Backpressure holds the word, then refill with no bubble.
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 2, 4'b0100, 0, 0);
      check("stall_rdy", 32'(seen_rdy), 32'h0);
      check("stall_data", out_data, held);
    end
    step(1, 0, 2, 4'b0100, 1, 32'h12345678);
    check("refill_rdy", 32'(seen_rdy), 32'h4);
    check("refill_valid", 32'(out_valid), 32'h1);
    check("refill_data", out_data, 32'h12345678);

    // Reset mid-operation discards the word.
    step(0, 0, 2, 4'b0100, 0, 0);
    check("rst_rdy", 32'(seen_rdy), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);

    // Round-robin from reset: 0,1,2,3,0 (select 0 without the feature).
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 4'b1111, 1, 0);
      check("rr_seq", 32'(seen_rdy),
            RR_EN ? (32'h1 << (k % CH)) : 32'h1);
    end

    // Wrap from ptr=1 to channel 0.
    step(0, 0, 0, 4'b0000, 1, 0);
    step(1, 1, 1, 4'b0010, 1, 0);
    check("wrap_pre", 32'(seen_rdy), 32'h2);
    step(1, 1, 0, 4'b0001, 1, 0);
    check("wrap_rdy", 32'(seen_rdy), 32'h1);

    // Out-of-range selector grants nobody.
    step(0, 0, 0, 4'b0000, 1, 0);
    step(1, 0, 5, 4'b1111, 1, 0);
    check("oor_rdy", 32'(seen_rdy), 32'h0);
    check("oor_valid", 32'(out_valid), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) >= 3), 1'($urandom()),
           SW'($urandom_range(0, 7)), CH'($urandom()),
           ($urandom_range(0, 3) != 0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
